// File: rtl/wb_regfile_if.sv
// Write-back slot, decode read ports and commit record of the write-back register file.
interface wb_regfile_if;
  logic [63:0] pc_i;
  logic [31:0] inst_i;
  logic        difftest_flush_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [63:0] wb_data_i;
  logic        inst_is_load_i;
  logic [63:0] mem_load_data_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [63:0] rs1_data_o;
  logic [63:0] rs2_data_o;
  logic        commit_valid_o;
  logic [63:0] commit_pc_o;
  logic [31:0] commit_inst_o;
  logic        commit_wen_o;
  logic [4:0]  commit_waddr_o;
  logic [63:0] commit_wdata_o;
  logic [63:0] retire_cnt_o;

  modport master (
    output pc_i, inst_i, difftest_flush_i, wb_en_i, wb_addr_i, wb_data_i,
    output inst_is_load_i, mem_load_data_i, rs1_addr_i, rs2_addr_i,
    input  rs1_data_o, rs2_data_o, commit_valid_o, commit_pc_o, commit_inst_o,
    input  commit_wen_o, commit_waddr_o, commit_wdata_o, retire_cnt_o
  );

  modport slave (
    input  pc_i, inst_i, difftest_flush_i, wb_en_i, wb_addr_i, wb_data_i,
    input  inst_is_load_i, mem_load_data_i, rs1_addr_i, rs2_addr_i,
    output rs1_data_o, rs2_data_o, commit_valid_o, commit_pc_o, commit_inst_o,
    output commit_wen_o, commit_waddr_o, commit_wdata_o, retire_cnt_o
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: load extension, 31x64 register file, registered commit record and
// retire counter. Define WB_BYPASS_EN to make the read ports write-through.
module wb_regfile (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  logic [2:0]  funct3;
  logic [63:0] wval;
  logic        we;

  logic [63:0] regs_q [31:1];
  logic [63:0] regs_d [31:1];

  logic        commit_valid_q, commit_valid_d;
  logic [63:0] commit_pc_q, commit_pc_d;
  logic [31:0] commit_inst_q, commit_inst_d;
  logic        commit_wen_q, commit_wen_d;
  logic [4:0]  commit_waddr_q, commit_waddr_d;
  logic [63:0] commit_wdata_q, commit_wdata_d;
  logic [63:0] retire_cnt_q, retire_cnt_d;

  assign funct3 = bus.inst_i[14:12];
  assign we     = bus.wb_en_i & ~bus.difftest_flush_i & (bus.wb_addr_i != 5'd0);

  always_comb begin
    wval = bus.wb_data_i;
    if (bus.inst_is_load_i) begin
      unique case (funct3)
        3'b000:  wval = {{56{bus.mem_load_data_i[7]}}, bus.mem_load_data_i[7:0]};
        3'b001:  wval = {{48{bus.mem_load_data_i[15]}}, bus.mem_load_data_i[15:0]};
        3'b010:  wval = {{32{bus.mem_load_data_i[31]}}, bus.mem_load_data_i[31:0]};
        3'b011:  wval = bus.mem_load_data_i;
        3'b100:  wval = {56'd0, bus.mem_load_data_i[7:0]};
        3'b101:  wval = {48'd0, bus.mem_load_data_i[15:0]};
        3'b110:  wval = {32'd0, bus.mem_load_data_i[31:0]};
        default: wval = 64'd0;
      endcase
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[bus.wb_addr_i] = wval;
    end
  end

  // we already excludes x0 and bubbles, so the bypass inherits those exclusions.
  always_comb begin
    bus.rs1_data_o = 64'd0;
    bus.rs2_data_o = 64'd0;
    if (bus.rs1_addr_i != 5'd0) begin
      bus.rs1_data_o = regs_q[bus.rs1_addr_i];
    end
    if (bus.rs2_addr_i != 5'd0) begin
      bus.rs2_data_o = regs_q[bus.rs2_addr_i];
    end
`ifdef WB_BYPASS_EN
    if (we && (bus.rs1_addr_i == bus.wb_addr_i)) begin
      bus.rs1_data_o = wval;
    end
    if (we && (bus.rs2_addr_i == bus.wb_addr_i)) begin
      bus.rs2_data_o = wval;
    end
`endif
  end

  always_comb begin
    commit_valid_d = ~bus.difftest_flush_i;
    commit_pc_d    = bus.pc_i;
    commit_inst_d  = bus.inst_i;
    commit_wen_d   = we;
    commit_waddr_d = bus.wb_addr_i;
    commit_wdata_d = wval;
    retire_cnt_d   = retire_cnt_q + {63'd0, ~bus.difftest_flush_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 64'd0;
      end
      commit_valid_q <= 1'b0;
      commit_pc_q    <= 64'd0;
      commit_inst_q  <= 32'd0;
      commit_wen_q   <= 1'b0;
      commit_waddr_q <= 5'd0;
      commit_wdata_q <= 64'd0;
      retire_cnt_q   <= 64'd0;
    end else begin
      regs_q         <= regs_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_inst_q  <= commit_inst_d;
      commit_wen_q   <= commit_wen_d;
      commit_waddr_q <= commit_waddr_d;
      commit_wdata_q <= commit_wdata_d;
      retire_cnt_q   <= retire_cnt_d;
    end
  end

  assign bus.commit_valid_o = commit_valid_q;
  assign bus.commit_pc_o    = commit_pc_q;
  assign bus.commit_inst_o  = commit_inst_q;
  assign bus.commit_wen_o   = commit_wen_q;
  assign bus.commit_waddr_o = commit_waddr_q;
  assign bus.commit_wdata_o = commit_wdata_q;
  assign bus.retire_cnt_o   = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected read and commit results,
// a negedge monitor pops and compares them.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        full;
    logic        valid;
    logic        wen;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] cnt;
  } cexp_t;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
  } rexp_t;

  cexp_t commit_q [$];
  rexp_t rd_q [$];
  cexp_t mc;
  rexp_t mr;

  int n_cmp  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  logic [63:0] mregs [0:31];
  logic [63:0] mcnt;
  logic [63:0] pc_ctr = 64'h8000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (commit_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL commit_q underflow: got empty queue, expected an entry (t=%0t)", $time);
      end else begin
        mc = commit_q.pop_front();
        chk("commit_valid", {63'd0, bus.commit_valid_o}, {63'd0, mc.valid});
        chk("commit_wen", {63'd0, bus.commit_wen_o}, {63'd0, mc.wen});
        chk("retire_cnt", bus.retire_cnt_o, mc.cnt);
        if (mc.full) begin
          chk("commit_pc", bus.commit_pc_o, mc.pc);
          chk("commit_inst", {32'd0, bus.commit_inst_o}, {32'd0, mc.inst});
          chk("commit_waddr", {59'd0, bus.commit_waddr_o}, {59'd0, mc.waddr});
          chk("commit_wdata", bus.commit_wdata_o, mc.wdata);
        end
      end
      if (rd_q.size() != 0) begin
        mr = rd_q.pop_front();
        chk("rs1_data", bus.rs1_data_o, mr.rs1);
        chk("rs2_data", bus.rs2_data_o, mr.rs2);
      end
    end
  end

  function automatic logic [63:0] rd_model(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [63:0] wval);
    if (a == 5'd0) return 64'd0;
`ifdef WB_BYPASS_EN
    if (we && (a == wa)) return wval;
`endif
    return mregs[a];
  endfunction

  // Drive one WB slot for one cycle; wval is the hand-computed write value.
  task automatic slot(input logic r, input logic fl, input logic en, input logic [4:0] wa,
                      input logic [63:0] wd, input logic ld, input logic [2:0] f3,
                      input logic [63:0] md, input logic [63:0] wval,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic  we;
    cexp_t c;
    rexp_t e;
    rst                  = r;
    bus.pc_i             = pc_ctr;
    bus.inst_i           = {17'd0, f3, 5'd0, (ld ? 7'h03 : 7'h13)};
    bus.difftest_flush_i = fl;
    bus.wb_en_i          = en;
    bus.wb_addr_i        = wa;
    bus.wb_data_i        = wd;
    bus.inst_is_load_i   = ld;
    bus.mem_load_data_i  = md;
    bus.rs1_addr_i       = r1;
    bus.rs2_addr_i       = r2;
    we = en & ~fl & (wa != 5'd0);
    e.rs1 = rd_model(r1, we, wa, wval);
    e.rs2 = rd_model(r2, we, wa, wval);
    rd_q.push_back(e);
    if (r) begin
      c = '{full: 1'b1, valid: 1'b0, wen: 1'b0, pc: 64'd0, inst: 32'd0, waddr: 5'd0,
            wdata: 64'd0, cnt: 64'd0};
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      mcnt = 64'd0;
    end else begin
      if (we) mregs[wa] = wval;
      if (!fl) mcnt = mcnt + 64'd1;
      c = '{full: ~fl, valid: ~fl, wen: we, pc: bus.pc_i, inst: bus.inst_i, waddr: wa,
            wdata: wval, cnt: mcnt};
    end
    commit_q.push_back(c);
    pc_ctr = pc_ctr + 64'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b1;
    bus.pc_i             = 64'd0;
    bus.inst_i           = 32'd0;
    bus.difftest_flush_i = 1'b1;
    bus.wb_en_i          = 1'b0;
    bus.wb_addr_i        = 5'd0;
    bus.wb_data_i        = 64'd0;
    bus.inst_is_load_i   = 1'b0;
    bus.mem_load_data_i  = 64'd0;
    bus.rs1_addr_i       = 5'd0;
    bus.rs2_addr_i       = 5'd0;
    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    mcnt = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    commit_q.push_back('{full: 1'b1, valid: 1'b0, wen: 1'b0, pc: 64'd0, inst: 32'd0,
                         waddr: 5'd0, wdata: 64'd0, cnt: 64'd0});
    mon_en = 1'b1;

    // Reset state of the file, then LD x5.
    slot(0, 1, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 5, 31);
    slot(0, 0, 1, 5, 64'd0, 1, 3'd3, 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 5, 6);
    // Load extensions into x6.
    slot(0, 0, 1, 6, 64'd0, 1, 3'd0, 64'h8000_8080, 64'hFFFF_FFFF_FFFF_FF80, 5, 6);
    slot(0, 0, 1, 6, 64'd0, 1, 3'd4, 64'h8000_8080, 64'h0000_0000_0000_0080, 6, 5);
    slot(0, 0, 1, 6, 64'd0, 1, 3'd1, 64'h8000_8080, 64'hFFFF_FFFF_FFFF_8080, 6, 5);
    slot(0, 0, 1, 6, 64'd0, 1, 3'd5, 64'h8000_8080, 64'h0000_0000_0000_8080, 6, 5);
    slot(0, 0, 1, 6, 64'd0, 1, 3'd2, 64'h8000_8080, 64'hFFFF_FFFF_8000_8080, 6, 5);
    slot(0, 0, 1, 6, 64'd0, 1, 3'd6, 64'h8000_8080, 64'h0000_0000_8000_8080, 6, 5);
    slot(0, 0, 1, 8, 64'd0, 1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6, 8);
    // x0 write is discarded but still retires.
    slot(0, 0, 1, 0, 64'h1234, 0, 3'd0, 64'd0, 64'h1234, 0, 0);
    slot(0, 0, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 0, 6);
    // x7 write-through check, both ports on the same register.
    slot(0, 0, 1, 7, 64'h1, 0, 3'd0, 64'd0, 64'h1, 7, 8);
    slot(0, 0, 1, 7, 64'hABCD, 0, 3'd0, 64'd0, 64'hABCD, 7, 7);
    slot(0, 1, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 7, 7);
    // Valid / bubble alternation on x9; bubbles carry wb_en_i=1.
    slot(0, 0, 1, 9, 64'h11, 0, 3'd0, 64'd0, 64'h11, 9, 0);
    slot(0, 1, 1, 9, 64'hDEAD, 0, 3'd0, 64'd0, 64'hDEAD, 9, 0);
    slot(0, 0, 1, 9, 64'h22, 0, 3'd0, 64'd0, 64'h22, 9, 0);
    slot(0, 1, 1, 9, 64'hDEAD, 0, 3'd0, 64'd0, 64'hDEAD, 9, 0);
    slot(0, 0, 1, 9, 64'h33, 0, 3'd0, 64'd0, 64'h33, 9, 0);
    slot(0, 1, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 9, 9);
    // Reset dominates a valid write, then count to 5 and reset mid-stream.
    slot(1, 0, 1, 10, 64'h55, 0, 3'd0, 64'd0, 64'h55, 10, 9);
    slot(0, 0, 1, 10, 64'h77, 0, 3'd0, 64'd0, 64'h77, 10, 9);
    slot(0, 0, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 10, 5);
    slot(0, 0, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 10, 6);
    slot(0, 0, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 10, 7);
    slot(0, 0, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 10, 9);
    slot(1, 0, 1, 10, 64'h99, 0, 3'd0, 64'd0, 64'h99, 10, 0);
    slot(0, 0, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 10, 5);
    slot(0, 1, 0, 0, 64'd0, 0, 3'd0, 64'd0, 64'd0, 10, 7);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++;
    if (commit_q.size() != 0) begin
      n_fail++;
      $display("FAIL commit_q drain: got %0d entries left, expected 0", commit_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
